// File: rtl/quant_sequencer_pkg.sv
// quant_sequencer_pkg: shared state encoding, tag layout and zigzag scan ROM
// Items: state_e (IDLE/ISSUE/DRAIN/DONE), tag bit positions, ZIGZAG[k] raster address of zigzag position k.
package quant_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  localparam int BLOCK_LEN = 64;
  localparam int TAG_PAR = 7;
  localparam int TAG_RSV = 6;
  localparam int TAG_IDX_W = 6;
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  function automatic logic [7:0] make_tag(logic par, logic [TAG_IDX_W-1:0] idx);
    return {par, 1'b0, idx};
  endfunction
endpackage

// File: rtl/quant_sequencer_if.sv
// quant_sequencer_if: control, RAM read, divider and result signals of the quantizer sequencer
// slave: the sequencer side; master: the surrounding system (RAMs, divider, host, consumer).
interface quant_sequencer_if #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH = 8
);
  logic start;
  logic busy;
  logic done;
  logic [5:0] coef_addr;
  logic signed [DIVIDEND_WIDTH-1:0] coef_data;
  logic [5:0] qtab_addr;
  logic [DIVISOR_WIDTH-1:0] qtab_data;
  logic div_input_valid;
  logic [7:0] div_tag;
  logic signed [DIVIDEND_WIDTH-1:0] div_dividend;
  logic [DIVISOR_WIDTH-1:0] div_divisor;
  logic div_output_valid;
  logic [7:0] div_tag_out;
  logic signed [DIVIDEND_WIDTH-1:0] div_quotient;
  logic out_valid;
  logic [5:0] out_index;
  logic signed [DIVIDEND_WIDTH-1:0] out_data;
  logic tag_error;
  modport slave (
    input start, coef_data, qtab_data, div_output_valid, div_tag_out, div_quotient,
    output busy, done, coef_addr, qtab_addr, div_input_valid, div_tag, div_dividend,
    output div_divisor, out_valid, out_index, out_data, tag_error
  );
  modport master (
    output start, coef_data, qtab_data, div_output_valid, div_tag_out, div_quotient,
    input busy, done, coef_addr, qtab_addr, div_input_valid, div_tag, div_dividend,
    input div_divisor, out_valid, out_index, out_data, tag_error
  );
endinterface

// File: rtl/quant_bias.sv
// quant_bias: zero-safe divisor and round-half-away bias with saturation for the divider
// coef_i/q_i: raw coefficient and quantizer step; dividend_o/divisor_o: values to issue.
module quant_bias #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH = 8
) (
  input  logic signed [DIVIDEND_WIDTH-1:0] coef_i,
  input  logic [DIVISOR_WIDTH-1:0]         q_i,
  output logic signed [DIVIDEND_WIDTH-1:0] dividend_o,
  output logic [DIVISOR_WIDTH-1:0]         divisor_o
);
  localparam int W = DIVIDEND_WIDTH;
  localparam int Q = DIVISOR_WIDTH;
  logic signed [W:0] ext, half, d;
  always_comb begin
    divisor_o = (q_i == '0) ? Q'(1) : q_i;
    ext = {coef_i[W-1], coef_i};
    half = {{(W+1-Q){1'b0}}, divisor_o >> 1};
    d = coef_i[W-1] ? ext - half : ext + half;
    // top two bits disagree only when the biased value left the W-bit range
    dividend_o = (d[W] != d[W-1]) ? {d[W], {(W-1){~d[W]}}} : d[W-1:0];
  end
endmodule

// File: rtl/quant_sequencer.sv
// quant_sequencer: zigzag-ordered issue of one 8x8 block to a pipelined divider and in-order result collection
// clock/nreset: clock and async active-low reset; bus: start/busy/done, RAM reads, divider issue/result, output stream.
module quant_sequencer
  import quant_sequencer_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH = 8
) (
  input logic clock,
  input logic nreset,
  quant_sequencer_if.slave bus
);
  localparam int W = DIVIDEND_WIDTH;
  localparam int Q = DIVISOR_WIDTH;
  state_e state_q;
  logic [TAG_IDX_W-1:0] k_q;
  logic [6:0] rx_q;
  logic par_q, busy_q, done_q;
  logic [5:0] addr_q;
  logic v0_q, v1_q, div_v_q;
  logic [7:0] t0_q, t1_q, div_tag_q;
  logic signed [W-1:0] dvd, div_dvd_q, out_data_q;
  logic [Q-1:0] dvs, div_dvs_q;
  logic out_valid_q, tag_err_q;
  logic [5:0] out_index_q;
  logic accept;
  // a result is taken only while a block is open and only if it is the next one in sequence
  assign accept = bus.div_output_valid && (state_q == ISSUE || state_q == DRAIN) && !rx_q[6] &&
                  bus.div_tag_out[TAG_PAR] == par_q && !bus.div_tag_out[TAG_RSV] &&
                  bus.div_tag_out[TAG_IDX_W-1:0] == rx_q[5:0];
  quant_bias #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(Q)) u_bias (
    .coef_i(bus.coef_data),
    .q_i(bus.qtab_data),
    .dividend_o(dvd),
    .divisor_o(dvs)
  );
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      k_q <= '0;
      rx_q <= '0;
      par_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      v0_q <= 1'b0;
      t0_q <= '0;
    end else begin
      done_q <= 1'b0;
      v0_q <= 1'b0;
      if (accept) rx_q <= rx_q + 7'd1;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= ISSUE;
          k_q <= '0;
          rx_q <= '0;
          par_q <= ~par_q;
          busy_q <= 1'b1;
        end
        ISSUE: begin
          addr_q <= ZIGZAG[k_q];
          v0_q <= 1'b1;
          t0_q <= make_tag(par_q, k_q);
          k_q <= k_q + 1'b1;
          if (k_q == 6'(BLOCK_LEN - 1)) state_q <= DRAIN;
        end
        DRAIN: if (rx_q == 7'(BLOCK_LEN)) begin
          state_q <= DONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  // stage 1 waits for the RAM read, stage 2 registers the biased divider operands
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      v1_q <= 1'b0;
      t1_q <= '0;
      div_v_q <= 1'b0;
      div_tag_q <= '0;
      div_dvd_q <= '0;
      div_dvs_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      v1_q <= v0_q;
      t1_q <= t0_q;
      div_v_q <= v1_q;
      if (v1_q) begin
        div_tag_q <= t1_q;
        div_dvd_q <= dvd;
        div_dvs_q <= dvs;
      end
      out_valid_q <= accept;
      if (accept) begin
        out_index_q <= bus.div_tag_out[TAG_IDX_W-1:0];
        out_data_q <= bus.div_quotient;
      end
      tag_err_q <= tag_err_q | (bus.div_output_valid & ~accept);
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.coef_addr = addr_q;
  assign bus.qtab_addr = addr_q;
  assign bus.div_input_valid = div_v_q;
  assign bus.div_tag = div_tag_q;
  assign bus.div_dividend = div_dvd_q;
  assign bus.div_divisor = div_dvs_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data = out_data_q;
  assign bus.tag_error = tag_err_q;
endmodule
